// File: rtl/ula_pkg.sv
// Shared opcode constants and state/mode encodings for the ula_param ALU.
// Optional multiplier support is selected by the ULA_MUL_EN macro.
package ula_pkg;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ShSll = 2'd0,
    ShSrl = 2'd1,
    ShMul = 2'd2
  } sh_mode_t;

endpackage

// File: rtl/ula_shifter.sv
// Iterative datapath: one-bit shifts, or shift-add multiply when ULA_MUL_EN is defined.
// o_result/o_carry present the value after the current step; o_done flags the final step.
module ula_shifter import ula_pkg::*; #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_step,
  input  sh_mode_t         i_mode,
  input  logic [WIDTH-1:0] i_a,
`ifdef ULA_MUL_EN
  input  logic [WIDTH-1:0] i_mcand,
`endif
  input  logic [CNT_W-1:0] i_count,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  sh_mode_t         r_mode;
  logic [WIDTH-1:0] w_acc_d;
  logic             w_carry;

`ifdef ULA_MUL_EN
  // r_hi:r_acc form the 2*WIDTH product; r_acc starts as the multiplier.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] w_hi_d;
  logic [WIDTH:0]   w_sum;
`endif

  always_comb begin
    w_acc_d = r_acc;
    w_carry = 1'b0;
`ifdef ULA_MUL_EN
    w_hi_d  = r_hi;
    w_sum   = '0;
`endif
    case (r_mode)
      ShSll: begin
        w_carry = r_acc[WIDTH-1];
        w_acc_d = {r_acc[WIDTH-2:0], 1'b0};
      end
      ShSrl: begin
        w_carry = r_acc[0];
        w_acc_d = {1'b0, r_acc[WIDTH-1:1]};
      end
      default: begin
`ifdef ULA_MUL_EN
        w_sum   = {1'b0, r_hi} + (r_acc[0] ? {1'b0, r_mcand} : '0);
        w_hi_d  = w_sum[WIDTH:1];
        w_acc_d = {w_sum[0], r_acc[WIDTH-1:1]};
        w_carry = |w_hi_d;
`endif
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_mode <= ShSll;
`ifdef ULA_MUL_EN
      r_hi    <= '0;
      r_mcand <= '0;
`endif
    end else if (i_load) begin
      r_acc  <= i_a;
      r_cnt  <= i_count;
      r_mode <= i_mode;
`ifdef ULA_MUL_EN
      r_hi    <= '0;
      r_mcand <= i_mcand;
`endif
    end else if (i_step && (r_cnt != '0)) begin
      r_acc <= w_acc_d;
      r_cnt <= r_cnt - CNT_W'(1);
`ifdef ULA_MUL_EN
      r_hi  <= w_hi_d;
`endif
    end
  end

  assign o_done   = (r_cnt == CNT_W'(1));
  assign o_result = w_acc_d;
  assign o_carry  = w_carry;

endmodule

// File: rtl/ula_param.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative shifts, optional MUL.
// Define ULA_MUL_EN to build the shift-add multiplier for opcode 8.
module ula_param import ula_pkg::*; #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_state_d;
  logic [WIDTH-1:0] r_result;
  logic             r_carry, r_zero, r_neg, r_ovf;

  logic             w_idle, w_busy, w_is_shift, w_iter, w_load_alu, w_load_sh;
  logic [CNT_W-1:0] w_amt, w_count;
  sh_mode_t         w_mode;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_alu_res, w_sh_res, w_fin_res;
  logic             w_alu_c, w_alu_v, w_sh_c, w_sh_done, w_fin_c, w_fin_v;

  assign w_idle     = (r_state == StIdle);
  assign w_busy     = (r_state == StBusy);
  assign w_is_shift = (opcode == OP_SLL) || (opcode == OP_SRL);
  // Amounts at or beyond WIDTH saturate: WIDTH single-bit shifts already clear the word.
  assign w_amt      = (rb >= WIDTH'(WIDTH)) ? CNT_W'(WIDTH) : CNT_W'(rb);
`ifdef ULA_MUL_EN
  assign w_iter     = (w_is_shift && (w_amt != '0)) || (opcode == OP_MUL);
`else
  assign w_iter     = w_is_shift && (w_amt != '0);
`endif
  assign w_count    = w_is_shift ? w_amt : CNT_W'(WIDTH);
  assign w_mode     = (opcode == OP_SLL) ? ShSll : ((opcode == OP_SRL) ? ShSrl : ShMul);
  assign w_load_alu = w_idle && in_valid && !w_iter;
  assign w_load_sh  = w_busy && w_sh_done;

  always_comb begin
    w_sum     = '0;
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (opcode)
      OP_NOT: w_alu_res = ~ra;
      OP_AND: w_alu_res = ra & rb;
      OP_OR:  w_alu_res = ra | rb;
      OP_XOR: w_alu_res = ra ^ rb;
      OP_ADD: begin
        w_sum     = {1'b0, ra} + {1'b0, rb};
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (ra[WIDTH-1] == rb[WIDTH-1]) && (w_sum[WIDTH-1] != ra[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum     = {1'b0, ra} - {1'b0, rb};
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (ra[WIDTH-1] != rb[WIDTH-1]) && (w_sum[WIDTH-1] != ra[WIDTH-1]);
      end
      // Only zero-amount shifts reach this path.
      OP_SLL, OP_SRL: w_alu_res = ra;
      default: w_alu_res = '0;
    endcase
  end

  ula_shifter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_shifter (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_load   (w_idle && in_valid && w_iter),
    .i_step   (w_busy),
    .i_mode   (w_mode),
`ifdef ULA_MUL_EN
    .i_a      ((opcode == OP_MUL) ? rb : ra),
    .i_mcand  (ra),
`else
    .i_a      (ra),
`endif
    .i_count  (w_count),
    .o_done   (w_sh_done),
    .o_result (w_sh_res),
    .o_carry  (w_sh_c)
  );

  assign w_fin_res = w_load_sh ? w_sh_res : w_alu_res;
  assign w_fin_c   = w_load_sh ? w_sh_c   : w_alu_c;
  assign w_fin_v   = w_load_sh ? 1'b0     : w_alu_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (in_valid) w_state_d = w_iter ? StBusy : StDone;
      StBusy:  if (w_sh_done) w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load_alu || w_load_sh) begin
      r_result <= w_fin_res;
      r_carry  <= w_fin_c;
      r_zero   <= (w_fin_res == '0);
      r_neg    <= w_fin_res[WIDTH-1];
      r_ovf    <= w_fin_v;
    end
  end

  assign result    = r_result;
  assign carry_out = r_carry;
  assign zero      = r_zero;
  assign negative  = r_neg;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_ula_param.sv
// Scoreboard bench for ula_param (WIDTH=8): arithmetic reference model feeds a queue,
// a negedge monitor pops and checks results, flags, latency and DONE-hold behaviour.
module tb_ula_param;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = '0;
  logic [W-1:0] ra = '0;
  logic [W-1:0] rb = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out, zero, negative, overflow;

  ula_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .ra        (ra),
    .rb        (rb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic       c, z, n, v;
    int         lat;
    longint     acc;
  } exp_t;

  exp_t   exp_q[$];
  longint cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  int     rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'($urandom_range(0, 1));
    else               out_ready = (rdy_mode == 1);
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input longint acc);
    exp_t e;
    int n, full, s;
    n     = (int'(b) >= W) ? W : int'(b);
    full  = 0;
    s     = 0;
    e.r   = '0;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.lat = 1;
    e.acc = acc;
    case (op)
      4'd0: e.r = ~a;
      4'd1: e.r = a & b;
      4'd2: e.r = a | b;
      4'd3: e.r = a ^ b;
      4'd4: begin
        full = int'(a) + int'(b);
        e.r  = full[7:0];
        e.c  = (full > 255);
        s    = int'($signed(a)) + int'($signed(b));
        e.v  = (s > 127) || (s < -128);
      end
      4'd5: begin
        full = int'(a) - int'(b);
        e.r  = full[7:0];
        e.c  = (a < b);
        s    = int'($signed(a)) - int'($signed(b));
        e.v  = (s > 127) || (s < -128);
      end
      4'd6: begin
        full  = int'(a) << n;
        e.r   = full[7:0];
        e.c   = (n > 0) && (((int'(a) >> (W - n)) & 1) == 1);
        e.lat = n + 1;
      end
      4'd7: begin
        full  = int'(a) >> n;
        e.r   = full[7:0];
        e.c   = (n > 0) && (((int'(a) >> (n - 1)) & 1) == 1);
        e.lat = n + 1;
      end
`ifdef ULA_MUL_EN
      4'd8: begin
        full  = int'(a) * int'(b);
        e.r   = full[7:0];
        e.c   = ((full >> 8) != 0);
        e.lat = W + 1;
      end
`endif
      default: e.r = '0;
    endcase
    e.z = (e.r == 8'h00);
    e.n = e.r[7];
    return e;
  endfunction

  // Monitor
  logic       holding = 1'b0;
  logic       hs_prev = 1'b0;
  logic [11:0] held;
  exp_t       cur;

  always @(negedge clk) begin
    if (reset) begin
      holding = 1'b0;
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) chk("return_to_idle {out_valid,in_ready}", {62'b0, out_valid, in_ready}, 64'h1);
      if (out_valid) begin
        chk("in_ready_low_in_done", {63'b0, in_ready}, 64'h0);
        if (!holding) begin
          chk("output_expected", {63'b0, (exp_q.size() > 0)}, 64'h1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("result", {56'b0, result}, {56'b0, cur.r});
            chk("flags {c,z,n,v}", {60'b0, carry_out, zero, negative, overflow},
                {60'b0, cur.c, cur.z, cur.n, cur.v});
            chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
          end
          held    = {result, carry_out, zero, negative, overflow};
          holding = 1'b1;
        end else begin
          chk("hold_stable", {52'b0, result, carry_out, zero, negative, overflow}, {52'b0, held});
        end
        if (out_ready) holding = 1'b0;
      end
      hs_prev = out_valid && out_ready;
    end
  end

  // Garbage is driven on the inputs while the DUT is not ready; it must be ignored.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      opcode   = 4'($urandom);
      ra       = 8'($urandom);
      rb       = 8'($urandom);
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      chk("issue_wait_in_ready", {63'b0, in_ready}, 64'h1);
      in_valid = 1'b0;
    end else begin
      in_valid = 1'b1;
      opcode   = op;
      ra       = a;
      rb       = b;
      exp_q.push_back(model(op, a, b, cyc + 1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && in_ready) && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_queue_empty", 64'(exp_q.size()), 64'h0);
    chk("drain_in_ready", {63'b0, in_ready}, 64'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    logic [7:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state {in_ready,out_valid,result,c,z,n,v}",
        {50'b0, in_ready, out_valid, result, carry_out, zero, negative, overflow},
        {50'b0, 1'b1, 1'b0, 8'h00, 4'h0});
    reset = 1'b0;
    @(posedge clk);
    #1;

    rdy_mode = 1;
    issue(4'd4, 8'h7F, 8'h01);
    issue(4'd5, 8'h03, 8'h05);
    issue(4'd6, 8'h81, 8'd3);
    issue(4'd7, 8'h81, 8'd1);
    issue(4'd8, 8'h10, 8'h11);
    issue(4'd15, 8'hFF, 8'hFF);
    issue(4'd6, 8'hA5, 8'd0);
    issue(4'd7, 8'hA5, 8'd200);
    issue(4'd6, 8'h81, 8'd8);
    issue(4'd4, 8'hFF, 8'h01);
    wait_drain();

    // DONE held with out_ready low while junk requests arrive.
    rdy_mode = 2;
    issue(4'd4, 8'h40, 8'h40);
    repeat (7) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      opcode   = 4'($urandom);
      ra       = 8'($urandom);
      rb       = 8'($urandom);
    end
    in_valid = 1'b0;
    chk("hold_out_valid", {63'b0, out_valid}, 64'h1);
    chk("hold_in_ready", {63'b0, in_ready}, 64'h0);
    rdy_mode = 1;
    wait_drain();

    // Reset in the third BUSY cycle of a 7-bit shift.
    issue(4'd4, 8'h7F, 8'h01);
    wait_drain();
    issue(4'd6, 8'h5B, 8'd7);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    chk("mid_shift_reset {in_ready,out_valid,result,c,z,n,v}",
        {50'b0, in_ready, out_valid, result, carry_out, zero, negative, overflow},
        {50'b0, 1'b1, 1'b0, 8'h00, 4'h0});

    rdy_mode = 0;
    repeat (150) begin
      op = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 8)) : 4'($urandom);
      a  = 8'($urandom);
      b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      issue(op, a, b);
    end
    rdy_mode = 1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
